// File: rtl/mips_regfile_bist.sv
// Built-in self-test initiator for the mips_registers register file.
// Latency: start sampled at E0, 96 busy cycles (WRITE 32 / READ 16 per pass, two passes), done at E96.
// Backpressure: none; the register file is assumed always ready, start is ignored while busy.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   start               begin a test (accepted only in IDLE or DONE)
//   read_data_1/2       register file read port data (combinational from read_reg_*)
//   write_data/_reg     register file write port, signal_reg_write is its enable
//   read_reg_1/2        read addresses, even/odd pair during READ
//   busy, done          test running / test finished (held until next start)
//   fail, fail_reg      sticky mismatch flag and first failing register
//   fail_count          total mismatching reads, 0..64
module mips_regfile_bist #(
   parameter logic [31:0] SEED      = 32'h8EFDFBF7,
   parameter logic [31:0] STRIDE    = 32'h01010101,
   parameter bit          SKIP_ZERO = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] read_data_1,
   input  logic [31:0] read_data_2,
   output logic [31:0] write_data,
   output logic [4:0]  write_reg,
   output logic        signal_reg_write,
   output logic [4:0]  read_reg_1,
   output logic [4:0]  read_reg_2,
   output logic        busy,
   output logic        done,
   output logic        fail,
   output logic [4:0]  fail_reg,
   output logic [6:0]  fail_count
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic        pass_q, pass_d;
   logic [4:0]  wcnt_q, wcnt_d;
   logic [3:0]  rcnt_q, rcnt_d;
   logic        done_q, done_d;
   logic        fail_q, fail_d;
   logic [4:0]  fail_reg_q, fail_reg_d;
   logic [6:0]  fail_count_q, fail_count_d;

   logic        mis_1;
   logic        mis_2;
   logic [4:0]  even_reg;
   logic [4:0]  odd_reg;

   // Data written to register idx in the given pass; pass 1 is the inverse.
   function automatic logic [31:0] pattern(input logic p, input logic [4:0] idx);
      logic [31:0] d;
      d = SEED + ({27'd0, idx} * STRIDE);
      return p ? ~d : d;
   endfunction

   // Value the register file should return; $0 reads as zero when it is hardwired.
   function automatic logic [31:0] expected(input logic p, input logic [4:0] idx);
      if (SKIP_ZERO && (idx == 5'd0)) begin
         return 32'h0;
      end
      return pattern(p, idx);
   endfunction

   assign even_reg = {rcnt_q, 1'b0};
   assign odd_reg  = {rcnt_q, 1'b1};

   always_comb begin
      state_d          = state_q;
      pass_d           = pass_q;
      wcnt_d           = wcnt_q;
      rcnt_d           = rcnt_q;
      done_d           = done_q;
      fail_d           = fail_q;
      fail_reg_d       = fail_reg_q;
      fail_count_d     = fail_count_q;
      mis_1            = 1'b0;
      mis_2            = 1'b0;
      write_data       = 32'h0;
      write_reg        = 5'd0;
      signal_reg_write = 1'b0;
      read_reg_1       = 5'd0;
      read_reg_2       = 5'd0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d      = ST_WRITE;
               pass_d       = 1'b0;
               wcnt_d       = 5'd0;
               rcnt_d       = 4'd0;
               done_d       = 1'b0;
               fail_d       = 1'b0;
               fail_reg_d   = 5'd0;
               fail_count_d = 7'd0;
            end
         end

         ST_WRITE: begin
            signal_reg_write = 1'b1;
            write_reg        = wcnt_q;
            write_data       = pattern(pass_q, wcnt_q);
            wcnt_d           = wcnt_q + 5'd1;
            if (wcnt_q == 5'd31) begin
               state_d = ST_READ;
               rcnt_d  = 4'd0;
            end
         end

         ST_READ: begin
            read_reg_1   = even_reg;
            read_reg_2   = odd_reg;
            mis_1        = (read_data_1 != expected(pass_q, even_reg));
            mis_2        = (read_data_2 != expected(pass_q, odd_reg));
            fail_count_d = fail_count_q + {6'd0, mis_1} + {6'd0, mis_2};
            fail_d       = fail_q | mis_1 | mis_2;
            // Only the first failure is recorded; port 1 wins a same-cycle tie.
            if (!fail_q && (mis_1 || mis_2)) begin
               fail_reg_d = mis_1 ? even_reg : odd_reg;
            end
            rcnt_d = rcnt_q + 4'd1;
            if (rcnt_q == 4'd15) begin
               if (!pass_q) begin
                  state_d = ST_WRITE;
                  pass_d  = 1'b1;
                  wcnt_d  = 5'd0;
               end else begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         pass_q       <= 1'b0;
         wcnt_q       <= 5'd0;
         rcnt_q       <= 4'd0;
         done_q       <= 1'b0;
         fail_q       <= 1'b0;
         fail_reg_q   <= 5'd0;
         fail_count_q <= 7'd0;
      end else begin
         state_q      <= state_d;
         pass_q       <= pass_d;
         wcnt_q       <= wcnt_d;
         rcnt_q       <= rcnt_d;
         done_q       <= done_d;
         fail_q       <= fail_d;
         fail_reg_q   <= fail_reg_d;
         fail_count_q <= fail_count_d;
      end
   end

   assign busy       = (state_q == ST_WRITE) || (state_q == ST_READ);
   assign done       = done_q;
   assign fail       = fail_q;
   assign fail_reg   = fail_reg_q;
   assign fail_count = fail_count_q;

endmodule

// File: tb/tb_mips_regfile_bist.sv
module tb_mips_regfile_bist;

   localparam logic [31:0] SEED   = 32'h8EFDFBF7;
   localparam logic [31:0] STRIDE = 32'h01010101;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;

   // Instance a: SKIP_ZERO=1, instance b: SKIP_ZERO=0. Both share clk/reset/start.
   logic [31:0] rd1_a, rd2_a, wd_a, rd1_b, rd2_b, wd_b;
   logic [4:0]  wr_a, rr1_a, rr2_a, freg_a, wr_b, rr1_b, rr2_b, freg_b;
   logic        we_a, busy_a, done_a, fail_a, we_b, busy_b, done_b, fail_b;
   logic [6:0]  fcnt_a, fcnt_b;
   logic [62:0] outs_a, outs_b;

   logic [31:0] rf_a [32];
   logic [31:0] rf_b [32];
   bit          stuck_en;
   int          stuck_reg;
   int          stuck_bit;
   bit          stuck_val;
   logic [31:0] w2_seen [2];

   int errors = 0;
   int checks = 0;

   mips_regfile_bist u_dut_a (
      .clk(clk), .reset(reset), .start(start),
      .read_data_1(rd1_a), .read_data_2(rd2_a),
      .write_data(wd_a), .write_reg(wr_a), .signal_reg_write(we_a),
      .read_reg_1(rr1_a), .read_reg_2(rr2_a),
      .busy(busy_a), .done(done_a), .fail(fail_a),
      .fail_reg(freg_a), .fail_count(fcnt_a)
   );

   mips_regfile_bist #(.SKIP_ZERO(1'b0)) u_dut_b (
      .clk(clk), .reset(reset), .start(start),
      .read_data_1(rd1_b), .read_data_2(rd2_b),
      .write_data(wd_b), .write_reg(wr_b), .signal_reg_write(we_b),
      .read_reg_1(rr1_b), .read_reg_2(rr2_b),
      .busy(busy_b), .done(done_b), .fail(fail_b),
      .fail_reg(freg_b), .fail_count(fcnt_b)
   );

   assign outs_a = {wd_a, wr_a, we_a, rr1_a, rr2_a, busy_a, done_a, fail_a, freg_a, fcnt_a};
   assign outs_b = {wd_b, wr_b, we_b, rr1_b, rr2_b, busy_b, done_b, fail_b, freg_b, fcnt_b};

   always #5 clk = ~clk;

   // Register file models: $0 hardwired to zero, optional single stuck bit.
   always @(posedge clk) begin
      if (we_a) rf_a[wr_a] <= wd_a;
      if (we_b) rf_b[wr_b] <= wd_b;
   end

   function automatic logic [31:0] rf_view(input logic [31:0] v, input logic [4:0] a,
                                           input bit en, input int r, input int b, input bit sv);
      logic [31:0] x;
      x = (a == 5'd0) ? 32'h0 : v;
      if (en && int'(a) == r) x[b] = sv;
      return x;
   endfunction

   always_comb rd1_a = rf_view(rf_a[rr1_a], rr1_a, stuck_en, stuck_reg, stuck_bit, stuck_val);
   always_comb rd2_a = rf_view(rf_a[rr2_a], rr2_a, stuck_en, stuck_reg, stuck_bit, stuck_val);
   always_comb rd1_b = rf_view(rf_b[rr1_b], rr1_b, stuck_en, stuck_reg, stuck_bit, stuck_val);
   always_comb rd2_b = rf_view(rf_b[rr2_b], rr2_b, stuck_en, stuck_reg, stuck_bit, stuck_val);

   // Reference pattern straight from the arithmetic definition.
   function automatic logic [31:0] pat(input int p, input int i);
      logic [31:0] d;
      d = SEED + 32'(i) * STRIDE;
      return (p != 0) ? ~d : d;
   endfunction

   // Expected outcome of a full test: walk registers in read order, port 1 first.
   function automatic void model(input bit skip, output bit f, output logic [4:0] freg,
                                 output logic [6:0] cnt);
      logic [31:0] stored, exp;
      f = 1'b0; freg = 5'd0; cnt = 7'd0;
      for (int p = 0; p < 2; p++) begin
         for (int i = 0; i < 32; i++) begin
            stored = (i == 0) ? 32'h0 : pat(p, i);
            if (stuck_en && i == stuck_reg) stored[stuck_bit] = stuck_val;
            exp = (skip && i == 0) ? 32'h0 : pat(p, i);
            if (stored != exp) begin
               if (!f) freg = 5'(i);
               f = 1'b1;
               cnt = cnt + 7'd1;
            end
         end
      end
   endfunction

   // Pulse (or hold) start, then follow the run cycle by cycle against the timeline.
   task automatic run_bist(input int hold, output int nbusy);
      int n, p, i, k;
      logic [47:0] obs, exp;
      start = 1'b1;
      @(posedge clk); #1;
      n = 0;
      while (busy_a && n < 200) begin
         start = (n < hold);
         if (n == 0) begin
            checks++;
            if ({done_a, fail_a, freg_a, fcnt_a} !== 14'd0)
               $display("FAIL accept_clear: got done=%0b fail=%0b reg=%0d cnt=%0d want all 0",
                        done_a, fail_a, freg_a, fcnt_a);
               if ({done_a, fail_a, freg_a, fcnt_a} !== 14'd0) errors++;
         end
         if (n < 96) begin
            if (n < 32 || (n >= 48 && n < 80)) begin
               p = (n < 32) ? 0 : 1;
               i = (p == 1) ? n - 48 : n;
               exp = {1'b1, 5'(i), pat(p, i), 5'd0, 5'd0};
               if (i == 2) w2_seen[p] = wd_a;
            end else begin
               p = (n < 48) ? 0 : 1;
               k = (p == 1) ? n - 80 : n - 32;
               exp = {1'b0, 5'd0, 32'h0, 5'(2 * k), 5'(2 * k + 1)};
            end
            obs = {we_a, wr_a, wd_a, rr1_a, rr2_a};
            checks++;
            if (obs !== exp) begin
               errors++;
               $display("FAIL timeline cycle %0d: got %h want %h", n + 1, obs, exp);
            end
         end
         n++;
         @(posedge clk); #1;
      end
      start = 1'b0;
      nbusy = n;
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b0;
      #1;
      checks++;
      if (outs_a !== 63'd0 || outs_b !== 63'd0) begin
         errors++;
         $display("FAIL reset_outputs: got a=%h b=%h want 0", outs_a, outs_b);
      end
      start = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (outs_a !== 63'd0) begin
         errors++;
         $display("FAIL reset_holds: got %h want 0", outs_a);
      end
      start = 1'b0;
      #3 reset = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (outs_a !== 63'd0) begin
         errors++;
         $display("FAIL idle_after_reset: got %h want 0", outs_a);
      end
   endtask

   task automatic test_healthy;
      int nb;
      bit f; logic [4:0] fr; logic [6:0] c;
      stuck_en = 1'b0;
      run_bist(0, nb);
      checks++;
      if (nb != 96) begin
         errors++;
         $display("FAIL healthy_busy_cycles: got %0d want 96", nb);
      end
      checks++;
      if ({busy_a, done_a} !== 2'b01) begin
         errors++;
         $display("FAIL healthy_done: got busy=%0b done=%0b want busy=0 done=1", busy_a, done_a);
      end
      model(1'b1, f, fr, c);
      checks++;
      if ({fail_a, freg_a, fcnt_a} !== {f, fr, c}) begin
         errors++;
         $display("FAIL healthy_result: got fail=%0b reg=%0d cnt=%0d want %0b %0d %0d",
                  fail_a, freg_a, fcnt_a, f, fr, c);
      end
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if ({done_a, busy_a, fail_a, fcnt_a} !== {1'b1, 1'b0, f, c}) begin
         errors++;
         $display("FAIL done_stable: got done=%0b busy=%0b fail=%0b cnt=%0d", done_a, busy_a, fail_a, fcnt_a);
      end
   endtask

   task automatic test_write_pattern;
      checks++;
      if (w2_seen[0] !== 32'h90FFFDF9) begin
         errors++;
         $display("FAIL write_reg2_pass0: got %h want 90fffdf9", w2_seen[0]);
      end
      checks++;
      if (w2_seen[1] !== 32'h6F000206) begin
         errors++;
         $display("FAIL write_reg2_pass1: got %h want 6f000206", w2_seen[1]);
      end
   endtask

   task automatic test_skip_zero;
      bit f; logic [4:0] fr; logic [6:0] c;
      model(1'b0, f, fr, c);
      checks++;
      if ({fail_b, freg_b, fcnt_b, done_b} !== {f, fr, c, 1'b1}) begin
         errors++;
         $display("FAIL skip_zero_off: got fail=%0b reg=%0d cnt=%0d done=%0b want %0b %0d %0d 1",
                  fail_b, freg_b, fcnt_b, done_b, f, fr, c);
      end
   endtask

   task automatic test_stuck_reg5;
      int nb;
      bit f; logic [4:0] fr; logic [6:0] c;
      stuck_en = 1'b1; stuck_reg = 5; stuck_bit = 0; stuck_val = 1'b0;
      run_bist(0, nb);
      model(1'b1, f, fr, c);
      checks++;
      if (nb != 96 || {fail_a, freg_a, fcnt_a} !== {f, fr, c}) begin
         errors++;
         $display("FAIL stuck_reg5: got cycles=%0d fail=%0b reg=%0d cnt=%0d want 96 %0b %0d %0d",
                  nb, fail_a, freg_a, fcnt_a, f, fr, c);
      end
   endtask

   task automatic test_restart_after_fail;
      int nb, hold;
      checks++;
      if (fail_a !== 1'b1 || done_a !== 1'b1) begin
         errors++;
         $display("FAIL restart_precondition: got fail=%0b done=%0b want 1 1", fail_a, done_a);
      end
      stuck_en = 1'b0;
      hold = $urandom_range(2, 80);
      run_bist(hold, nb);
      checks++;
      if (nb != 96 || done_a !== 1'b1 || fail_a !== 1'b0 || fcnt_a !== 7'd0) begin
         errors++;
         $display("FAIL start_held_ignored: got cycles=%0d done=%0b fail=%0b cnt=%0d want 96 1 0 0",
                  nb, done_a, fail_a, fcnt_a);
      end
   endtask

   task automatic test_reset_midrun;
      int nb, c;
      for (int t = 0; t < 2; t++) begin
         c = (t == 0) ? 10 : int'($urandom_range(1, 96));
         start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         repeat (c - 1) @(posedge clk);
         #1;
         checks++;
         if (busy_a !== 1'b1 || (c <= 32 && {we_a, wr_a} !== {1'b1, 5'(c - 1)})) begin
            errors++;
            $display("FAIL pre_reset_cycle%0d: got busy=%0b we=%0b reg=%0d", c, busy_a, we_a, wr_a);
         end
         #2 reset = 1'b1;
         #1;
         checks++;
         if (outs_a !== 63'd0 || outs_b !== 63'd0) begin
            errors++;
            $display("FAIL async_reset_cycle%0d: got a=%h b=%h want 0", c, outs_a, outs_b);
         end
         #2 reset = 1'b0;
         @(posedge clk); #1;
         checks++;
         if (outs_a !== 63'd0) begin
            errors++;
            $display("FAIL after_abort_idle: got %h want 0", outs_a);
         end
         run_bist(0, nb);
         checks++;
         if (nb != 96 || done_a !== 1'b1 || fail_a !== 1'b0) begin
            errors++;
            $display("FAIL rerun_after_reset: got cycles=%0d done=%0b fail=%0b want 96 1 0",
                     nb, done_a, fail_a);
         end
      end
   endtask

   task automatic test_random_faults;
      int nb;
      bit f; logic [4:0] fr; logic [6:0] c;
      repeat (4) begin
         stuck_en  = 1'b1;
         stuck_reg = $urandom_range(1, 31);
         stuck_bit = $urandom_range(0, 31);
         stuck_val = 1'($urandom_range(0, 1));
         repeat ($urandom_range(0, 5)) @(posedge clk);
         #1;
         run_bist(0, nb);
         model(1'b1, f, fr, c);
         checks++;
         if (nb != 96 || {fail_a, freg_a, fcnt_a} !== {f, fr, c}) begin
            errors++;
            $display("FAIL random_fault_a r%0d b%0d v%0d: got cycles=%0d fail=%0b reg=%0d cnt=%0d want 96 %0b %0d %0d",
                     stuck_reg, stuck_bit, stuck_val, nb, fail_a, freg_a, fcnt_a, f, fr, c);
         end
         model(1'b0, f, fr, c);
         checks++;
         if ({fail_b, freg_b, fcnt_b} !== {f, fr, c}) begin
            errors++;
            $display("FAIL random_fault_b r%0d b%0d v%0d: got fail=%0b reg=%0d cnt=%0d want %0b %0d %0d",
                     stuck_reg, stuck_bit, stuck_val, fail_b, freg_b, fcnt_b, f, fr, c);
         end
      end
      stuck_en = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0;
      stuck_en = 1'b0; stuck_reg = 0; stuck_bit = 0; stuck_val = 1'b0;
      w2_seen[0] = 32'h0; w2_seen[1] = 32'h0;
      test_reset;
      test_healthy;
      test_write_pattern;
      test_skip_zero;
      test_stuck_reg5;
      test_restart_after_fail;
      test_reset_midrun;
      test_random_faults;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

endmodule
